// File: rtl/key_pio_pkg.sv
// Shared constants for the key PIO: Avalon register offsets and edge-type encodings.
// No state, no latency, no backpressure.
package key_pio_pkg;

  localparam logic [1:0] KEY_ADDR_DATA = 2'd0;
  localparam logic [1:0] KEY_ADDR_MASK = 2'd1;
  localparam logic [1:0] KEY_ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/key_debounce.sv
// One pin: 2-flop synchroniser then a saturating stability counter; level follows after
// DEBOUNCE_CYCLES stable cycles (2 + DEBOUNCE_CYCLES from pin). No backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= IDLE_LEVEL;
      s2 <= IDLE_LEVEL;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) level <= IDLE_LEVEL;
        else          level <= s2;
      end
    end else begin : g_count
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      localparam logic [CW-1:0] CNT_MAX  = '1;

      logic [CW-1:0] cnt;

      // Any bounce back to the accepted level restarts the count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt   <= '0;
          level <= IDLE_LEVEL;
        end else if (s2 == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= s2;
          cnt   <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/key_pio_edge.sv
// Avalon-MM input PIO: debounced DATA, RW MASK, W1C EDGE capture and a level IRQ.
// Read latency 1 cycle (readdata updates every clk); no wait states, no backpressure.
module key_pio_edge
  import key_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] rd_mux;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_LEVEL     (IDLE_LEVEL)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .level  (level[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    rise = level & ~level_d;
    fall = ~level & level_d;
    case (EDGE_TYPE)
      EDGE_RISE: det = rise;
      EDGE_FALL: det = fall;
      default:   det = rise | fall;
    endcase

    clr = '0;
    if (wr_en && address == KEY_ADDR_EDGE) clr = writedata;

    case (address)
      KEY_ADDR_DATA: rd_mux = level;
      KEY_ADDR_MASK: rd_mux = mask;
      KEY_ADDR_EDGE: rd_mux = edge_cap;
      default:       rd_mux = '0;
    endcase
  end

  // A new edge outranks a same-cycle clear so no press is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_d  <= {WIDTH{IDLE_LEVEL}};
      mask     <= '0;
      edge_cap <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      level_d  <= level;
      edge_cap <= (edge_cap & ~clr) | det;
      if (wr_en && address == KEY_ADDR_MASK) mask <= writedata;
      readdata <= rd_mux;
      irq      <= |(edge_cap & mask);
    end
  end

endmodule

// File: tb/tb_key_pio_edge.sv
// Scoreboard bench: a falling-edge and an any-edge PIO share pins and bus; a behavioural
// model queues the expected read response, a negedge monitor pops and compares.
module tb_key_pio_edge;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [W-1:0] writedata;
  logic [W-1:0] in_port;
  logic [W-1:0] rd_f;
  logic [W-1:0] rd_a;
  logic         irq_f;
  logic         irq_a;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_pio_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)) u_dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_f), .in_port(in_port), .irq(irq_f)
  );

  key_pio_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)) u_dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_port), .irq(irq_a)
  );

  typedef struct {
    logic [1:0]   addr;
    logic [W-1:0] rd_f;
    logic [W-1:0] rd_a;
    logic         irq_f;
    logic         irq_a;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pins reach the comparator 2 cycles late; a bit's level flips once the
  // last D comparator samples all disagree with it; edges are level changes seen one cycle on.
  logic [W-1:0] m_s1, m_s2, m_lvl, m_lvl_d, m_mask, t_nl, t_clr;
  logic [W-1:0] m_edge[2];
  logic [W-1:0] t_det[2];
  logic [W-1:0] t_rd[2];
  logic         t_irq[2];
  logic [W-1:0] hist[$];
  bit           t_ok;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '1; m_s2 = '1; m_lvl = '1; m_lvl_d = '1; m_mask = '0;
      m_edge[0] = '0; m_edge[1] = '0;
      hist.delete();
      for (int j = 0; j < D; j++) hist.push_back('1);
      exp_q.delete();
    end else begin
      hist.push_back(m_s2);
      void'(hist.pop_front());
      t_nl = m_lvl;
      for (int b = 0; b < W; b++) begin
        t_ok = 1'b1;
        foreach (hist[j]) if (hist[j][b] == m_lvl[b]) t_ok = 1'b0;
        if (t_ok) t_nl[b] = ~m_lvl[b];
      end
      t_det[0] = ~m_lvl & m_lvl_d;
      t_det[1] = m_lvl ^ m_lvl_d;
      t_clr = (chipselect && !write_n && address == 2'd3) ? writedata : '0;
      for (int k = 0; k < 2; k++) begin
        case (address)
          2'd0:    t_rd[k] = m_lvl;
          2'd1:    t_rd[k] = m_mask;
          2'd3:    t_rd[k] = m_edge[k];
          default: t_rd[k] = '0;
        endcase
        t_irq[k] = (m_edge[k] & m_mask) != '0;
      end
      if (chipselect && write_n)
        exp_q.push_back('{address, t_rd[0], t_rd[1], t_irq[0], t_irq[1]});
      for (int k = 0; k < 2; k++) m_edge[k] = (m_edge[k] & ~t_clr) | t_det[k];
      if (chipselect && !write_n && address == 2'd1) m_mask = writedata;
      m_lvl_d = m_lvl;
      m_lvl   = t_nl;
      m_s2    = m_s1;
      m_s1    = in_port;
    end
  end

  always @(negedge clk) begin
    if (reset_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("sb_rd_fall@%0d", e.addr), rd_f, e.rd_f);
      chk($sformatf("sb_rd_any@%0d", e.addr), rd_a, e.rd_a);
      chk("sb_irq_fall", W'(irq_f), W'(e.irq_f));
      chk("sb_irq_any", W'(irq_a), W'(e.irq_a));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [W-1:0] ef, input logic [W-1:0] ea);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    cyc();
    chipselect = 1'b0;
    @(negedge clk);
    chk($sformatf("dir_rd_fall@%0d", a), rd_f, ef);
    chk($sformatf("dir_rd_any@%0d", a), rd_a, ea);
    cyc();
  endtask

  task automatic irq_chk(input logic e);
    @(negedge clk);
    chk("dir_irq_fall", W'(irq_f), W'(e));
    chk("dir_irq_any", W'(irq_a), W'(e));
    cyc();
  endtask

  initial begin
    reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    in_port = 8'hFF;
    #2 reset_n = 1'b0;
    @(negedge clk);
    chk("reset_rd_fall", rd_f, 8'h00);
    chk("reset_rd_any", rd_a, 8'h00);
    chk("reset_irq", W'(irq_f | irq_a), 8'h00);
    idle(3);
    reset_n = 1'b1;

    rd_chk(2'd0, 8'hFF, 8'hFF);
    rd_chk(2'd3, 8'h00, 8'h00);
    irq_chk(1'b0);

    // bit0 press, then unmask it
    in_port = 8'hFE;
    idle(8);
    rd_chk(2'd0, 8'hFE, 8'hFE);
    rd_chk(2'd3, 8'h01, 8'h01);
    irq_chk(1'b0);
    wr(2'd1, 8'h01);
    irq_chk(1'b0);
    irq_chk(1'b1);

    // bit1 bouncing faster than the debounce window
    for (int i = 0; i < 10; i++) begin
      in_port[1] = ~in_port[1];
      idle(2);
    end
    in_port[1] = 1'b1;
    idle(8);
    rd_chk(2'd0, 8'hFE, 8'hFE);
    rd_chk(2'd3, 8'h01, 8'h01);

    // write-1-to-clear one bit at a time
    in_port = 8'hFC;
    idle(8);
    rd_chk(2'd3, 8'h03, 8'h03);
    wr(2'd1, 8'h03);
    wr(2'd3, 8'h01);
    rd_chk(2'd3, 8'h02, 8'h02);
    irq_chk(1'b1);
    wr(2'd3, 8'h02);
    irq_chk(1'b1);
    irq_chk(1'b0);
    rd_chk(2'd3, 8'h00, 8'h00);

    // bit2 edge lands in the same cycle as its clear
    in_port = 8'hF8;
    idle(6);
    wr(2'd3, 8'h04);
    rd_chk(2'd3, 8'h04, 8'h04);

    // bit3 falls then rises: only the any-edge instance captures the rise
    in_port = 8'hF0;
    idle(10);
    rd_chk(2'd3, 8'h0C, 8'h0C);
    wr(2'd3, 8'h0F);
    in_port = 8'hF8;
    idle(10);
    rd_chk(2'd3, 8'h00, 8'h08);
    wr(2'd2, 8'hFF);
    rd_chk(2'd0, 8'hF8, 8'hF8);
    rd_chk(2'd1, 8'h03, 8'h03);
    rd_chk(2'd2, 8'h00, 8'h00);
    rd_chk(2'd3, 8'h00, 8'h08);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 9) == 0) in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
      address   = 2'($urandom_range(0, 3));
      writedata = W'($urandom);
      case ($urandom_range(0, 99)) inside
        [0:39]:  begin chipselect = 1'b1; write_n = 1'b1; end
        [40:54]: begin chipselect = 1'b1; write_n = 1'b0; end
        default: begin chipselect = 1'b0; write_n = 1'($urandom_range(0, 1)); end
      endcase
      if (n == 2000) begin
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrun_reset_rd", rd_f | rd_a, 8'h00);
        cyc();
        cyc();
        reset_n = 1'b1;
      end
      cyc();
    end

    chipselect = 1'b0; write_n = 1'b1;
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
